// File: rtl/sram_arbiter.sv
// sram_arbiter: two-master arbiter in front of a single-port SRAM.
// m0 (instruction fetch, read-only) and m1 (load/store) share the port.
// m1 has default priority; m0 is forced through after MAX_WAIT denied cycles.
// Grants and the SRAM command are combinational in the request cycle.
// Read data comes back one cycle later and goes to the master that issued it.
module sram_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                resetn,

    input  logic                m0_req,
    input  logic [ADDR_W-1:0]   m0_addr,
    output logic                m0_gnt,
    output logic                m0_rvalid,
    output logic [DATA_W-1:0]   m0_rdata,

    input  logic                m1_req,
    input  logic [DATA_W/8-1:0] m1_we,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    output logic                m1_gnt,
    output logic                m1_rvalid,
    output logic [DATA_W-1:0]   m1_rdata,

    output logic                sram_en,
    output logic [DATA_W/8-1:0] sram_we,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_wdata,
    input  logic [DATA_W-1:0]   sram_rdata
);

    localparam int unsigned BE_W    = DATA_W / 8;
    localparam int unsigned CNT_RAW = $clog2(MAX_WAIT + 1);
    localparam int unsigned CNT_W   = (CNT_RAW > 3) ? CNT_RAW : 3;

    logic [CNT_W-1:0] wait_cnt;
    logic             m0_force;
    logic             rd_accept;
    logic             rd_vld_q;
    logic             rd_m1_q;

    // m0 starvation override once it has waited MAX_WAIT cycles
    assign m0_force = m0_req && (wait_cnt == CNT_W'(MAX_WAIT));

    // Grant selection: m1 first unless m0 is being forced; nothing in reset
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (resetn) begin
            if (m0_force) begin
                m0_gnt = 1'b1;
            end else if (m1_req) begin
                m1_gnt = 1'b1;
            end else if (m0_req) begin
                m0_gnt = 1'b1;
            end
        end
    end

    // SRAM command mux; only m1 can write, so m0 accesses force we to zero
    always_comb begin
        sram_en    = m0_gnt || m1_gnt;
        sram_we    = m1_gnt ? m1_we : BE_W'(0);
        sram_addr  = m1_gnt ? m1_addr : m0_addr;
        sram_wdata = m1_wdata;
    end

    // A read is any m0 grant or an m1 grant with no byte enables
    assign rd_accept = m0_gnt || (m1_gnt && (m1_we == BE_W'(0)));

    // Starvation counter for m0
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wait_cnt <= CNT_W'(0);
        end else if (m0_req && !m0_gnt) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end else begin
            wait_cnt <= CNT_W'(0);
        end
    end

    // Owner tag of the read in flight: {valid, issued by m1}
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_vld_q <= 1'b0;
            rd_m1_q  <= 1'b0;
        end else begin
            rd_vld_q <= rd_accept;
            rd_m1_q  <= rd_accept && m1_gnt;
        end
    end

    // Response routing: flop-decoded valids, shared data path
    assign m0_rvalid = rd_vld_q && !rd_m1_q;
    assign m1_rvalid = rd_vld_q && rd_m1_q;
    assign m0_rdata  = sram_rdata;
    assign m1_rdata  = sram_rdata;

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: address width of both requesters and of the SRAM port.
REQ-002 Parameter DATA_W, default 32: data width; DATA_W/8 byte-write lanes.
REQ-003 Parameter MAX_WAIT, default 4: consecutive denied cycles of m0 before m0 is forced to win.
REQ-004 clk  in  1: single clock; all state updates on the posedge.
REQ-005 resetn  in  1: asynchronous, active-low reset.
REQ-006 m0_req  in  1: instruction-fetch read request.
REQ-007 m0_addr  in  ADDR_W: instruction-fetch address.
REQ-008 m0_gnt  out  1: m0 request accepted this cycle.
REQ-009 m0_rvalid  out  1: m0 read data valid.
REQ-010 m0_rdata  out  DATA_W: m0 read data.
REQ-011 m1_req  in  1: data-access request, load or store.
REQ-012 m1_we  in  DATA_W/8: byte write enables; zero means read.
REQ-013 m1_addr  in  ADDR_W: data-access address.
REQ-014 m1_wdata  in  DATA_W: store data.
REQ-015 m1_gnt  out  1: m1 request accepted this cycle.
REQ-016 m1_rvalid  out  1: m1 read data valid.
REQ-017 m1_rdata  out  DATA_W: m1 read data.
REQ-018 sram_en  out  1: SRAM access enable.
REQ-019 sram_we  out  DATA_W/8: SRAM byte write enables.
REQ-020 sram_addr  out  ADDR_W: SRAM address.
REQ-021 sram_wdata  out  DATA_W: SRAM write data.
REQ-022 sram_rdata  in  DATA_W: SRAM read data, valid the cycle after a read is enabled.

Function
REQ-023 At most one of m0_gnt and m1_gnt SHALL be high in any cycle; a grant SHALL only be given to an asserted req.
REQ-024 Grants SHALL be combinational in the request cycle; a request is accepted exactly when its req and gnt are both high at a posedge.
REQ-025 Default priority SHALL be m1 over m0.
REQ-026 A 3-bit-or-wider counter wait_cnt SHALL increment on each cycle where m0_req=1 and m0_gnt=0, and SHALL clear on any cycle where m0_gnt=1 or m0_req=0.
REQ-027 When wait_cnt equals MAX_WAIT and m0_req=1, m0 SHALL be granted over a pending m1_req.
REQ-028 The granted master's addr/we/wdata SHALL be driven on the SRAM port. sram_en SHALL equal m0_gnt or m1_gnt. sram_we SHALL be m1_we when m1 is granted, otherwise zero.
REQ-029 A registered owner tag SHALL record {read accepted, which master} at each accepted read; stores set no tag.
REQ-030 Read latency SHALL be exactly 1 cycle. mX_rvalid SHALL be high in the cycle after mX's read is accepted, and mX_rdata SHALL equal sram_rdata in that cycle.
REQ-031 Back-to-back reads, including alternating masters, SHALL be sustained at one per cycle, each response routed only to its owner.
REQ-032 The rvalid of the non-owning master SHALL be 0. rdata of a master SHALL be don't-care when its rvalid is 0.
REQ-033 A store SHALL produce no rvalid on either master.
REQ-034 With no request, sram_en=0, sram_we=0, and the owner tag clears the next cycle.
REQ-035 Requesters may hold req across denied cycles with stable payload. The arbiter SHALL NOT require req to drop after a grant.

Reset
REQ-036 resetn=0 SHALL asynchronously clear wait_cnt, the owner tag, m0_rvalid and m1_rvalid.
REQ-037 While resetn=0, m0_gnt, m1_gnt, sram_en and sram_we SHALL be 0.
REQ-038 A read accepted in the cycle before reset asserts SHALL produce no rvalid after reset.
REQ-039 The first request after resetn rises SHALL be granted in that same cycle by the priority rules.

Verification
REQ-040 Scenario: m0 read 0x100 alone; sram_rdata=0xDEADBEEF next cycle. Required: m0_gnt same cycle, m0_rvalid=1 with m0_rdata=0xDEADBEEF next cycle, m1_rvalid=0.
REQ-041 Scenario: m0_req and m1_req (read) both high for one cycle. Required: m1_gnt=1 and m0_gnt=0; then m0_gnt=1 in the following cycle.
REQ-042 Scenario: m1_req held high continuously with m0_req high, MAX_WAIT=4. Required: m0 denied for 4 cycles and granted on the 5th cycle, then m1 regains priority.
REQ-043 Scenario: m1 store of 0x12345678 to 0x200 with we=4'b0011. Required: sram_we=4'b0011, sram_wdata=0x12345678, no rvalid on either master.
REQ-044 Scenario: alternating reads m1, m0, m1 on consecutive cycles. Required: rvalid pulses m1, m0, m1 one cycle later, each carrying its own data.
REQ-045 Scenario: resetn pulled low mid-cycle right after an accepted m0 read. Required: m0_rvalid=0 immediately and stays 0; wait_cnt=0.
